adc_trigger_capture: RTL and testbench

- Sits directly downstream of the ADC driver. Takes its registered 9-bit sample output and the ADC sample clock it produces.
- Runs entirely on CLK_64MHZ. Detects the trigger crossing and writes a pre/post-trigger window into the sample RAM (circular buffer).
- Reports completion, and the RAM address of the trigger sample, to the display/readout logic.

---
 rtl/scope_capture_pkg.sv | 17 +
 rtl/adc_strobe_gen.sv | 28 ++
 rtl/adc_trigger_capture.sv | 189 ++++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_capture_pkg.sv
// Shared constants for the ADC trigger/capture slice.
// State encoding, slope codes and default widths.
package scope_capture_pkg;

  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/adc_strobe_gen.sv
// CLK_ADC rising-edge detect, delayed one cycle.
// The delay lets the driver's sample settle before use.
module adc_strobe_gen (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clk_adc,
  output logic o_stb
);

  logic r_clk_q;
  logic r_stb;
  logic w_rise;

  assign w_rise = i_clk_adc & ~r_clk_q;
  assign o_stb  = r_stb;

  // register the ADC clock and the delayed edge pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_q <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_clk_q <= i_clk_adc;
      r_stb   <= w_rise;
    end
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Trigger detect and pre/post window capture into a circular RAM.
// Optional auto trigger on WAIT timeout: define ADC_TRIG_AUTO_EN.
module adc_trigger_capture
  import scope_capture_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int PRETRIG      = 256,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              CLK_64MHZ,
  input  logic              MASTER_RST_N,
  input  logic              CLK_ADC,
  input  logic [DATA_W-1:0] ADC_SAMPLE,
  input  logic [DATA_W-1:0] TRIG_LEVEL,
  input  logic              TRIG_SLOPE,
  input  logic              ARM,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              AUTO_FLAG,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int POST_LEN = DEPTH - PRETRIG;
  localparam int CNT_W    = ADDR_W + 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_LEN - 1);

  if (PRETRIG < 1 || PRETRIG >= DEPTH || AUTO_TIMEOUT < 1) begin : g_bad_cfg
    $error("adc_trigger_capture: PRETRIG or AUTO_TIMEOUT out of range");
  end

  logic              w_stb;
  logic              w_busy;
  logic              w_write;
  logic              w_hit;
  logic              w_tmo;
  logic              w_trig;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_wptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_done;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  adc_strobe_gen u_stb (
    .i_clk     (CLK_64MHZ),
    .i_rst_n   (MASTER_RST_N),
    .i_clk_adc (CLK_ADC),
    .o_stb     (w_stb)
  );

  assign w_busy  = (r_state == ST_PRE) |
                   (r_state == ST_WAIT) |
                   (r_state == ST_POST);
  assign w_write = w_stb & w_busy & ~ARM;
  assign w_trig  = (r_state == ST_WAIT) & (w_hit | w_tmo);

  // threshold crossing between the last written and current sample
  always_comb begin
    w_hit = 1'b0;
    unique case (TRIG_SLOPE)
      SLOPE_RISE: w_hit = r_prev_valid &
                          (r_prev < TRIG_LEVEL) &
                          (ADC_SAMPLE >= TRIG_LEVEL);
      SLOPE_FALL: w_hit = r_prev_valid &
                          (r_prev > TRIG_LEVEL) &
                          (ADC_SAMPLE <= TRIG_LEVEL);
      default:    w_hit = 1'b0;
    endcase
  end

`ifdef ADC_TRIG_AUTO_EN
  localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo;
  logic             r_auto;

  assign w_tmo     = (r_tmo == TMO_W'(AUTO_TIMEOUT - 1));
  assign AUTO_FLAG = r_auto;

  // WAIT strobe counter, zero whenever outside WAIT
  always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) begin
      r_tmo <= '0;
    end else if (ARM || r_state != ST_WAIT) begin
      r_tmo <= '0;
    end else if (w_stb) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // flag a forced trigger, held until re-armed
  always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) begin
      r_auto <= 1'b0;
    end else if (ARM) begin
      r_auto <= 1'b0;
    end else if (w_write && w_trig && !w_hit) begin
      r_auto <= 1'b1;
    end
  end
`else
  assign w_tmo     = 1'b0;
  assign AUTO_FLAG = 1'b0;
`endif

  // write path, sequencing and trigger latch
  always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) begin
      r_state      <= ST_IDLE;
      r_wptr       <= '0;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_trig_addr  <= '0;
      r_done       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr    <= r_wptr;
        r_wr_data    <= ADC_SAMPLE;
        r_wptr       <= r_wptr + 1'b1;
        r_prev       <= ADC_SAMPLE;
        r_prev_valid <= 1'b1;
      end
      if (ARM) begin
        r_state      <= ST_PRE;
        r_wptr       <= '0;
        r_cnt        <= '0;
        r_done       <= 1'b0;
        r_prev_valid <= 1'b0;
      end else if (w_write) begin
        unique case (r_state)
          ST_PRE: begin
            if (r_cnt == PRE_LAST) begin
              r_state <= ST_WAIT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (w_trig) begin
              r_trig_addr <= r_wptr;
              r_cnt       <= CNT_W'(1);
              if (POST_LAST == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (r_cnt == POST_LAST) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign BUSY      = w_busy;
  assign DONE      = r_done;
  assign TRIG_ADDR = r_trig_addr;
  assign WR_EN     = r_wr_en;
  assign WR_ADDR   = r_wr_addr;
  assign WR_DATA   = r_wr_data;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Self-checking bench for adc_trigger_capture.
// Stream-level reference model; auto trigger under ADC_TRIG_AUTO_EN.
module tb_adc_trigger_capture;

  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int POSTN = DEPTH - PRE;
  localparam int ATO   = 8;

  typedef struct {
    int start;
    int step;
    int lvl;
    bit slope;
    int len;
    bit exp_done;
    int exp_addr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_adc;
  logic [8:0] sample;
  logic [8:0] level;
  logic       slope;
  logic       arm;
  logic       busy;
  logic       done;
  logic [3:0] trig_addr;
  logic       auto_f;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [8:0] wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hp = 512;
  int rise_cyc = -1;
  int pres_idx = 0;
  bit m_auto;

  logic [8:0] stim[$];
  int stream[$];
  int wa[$];
  int wd[$];
  int mram[DEPTH];
  vec_t tab[6];

  adc_trigger_capture #(
    .DATA_W(9), .ADDR_W(4), .PRETRIG(PRE), .AUTO_TIMEOUT(ATO)
  ) dut (
    .CLK_64MHZ    (clk),
    .MASTER_RST_N (rst_n),
    .CLK_ADC      (clk_adc),
    .ADC_SAMPLE   (sample),
    .TRIG_LEVEL   (level),
    .TRIG_SLOPE   (slope),
    .ARM          (arm),
    .BUSY         (busy),
    .DONE         (done),
    .TRIG_ADDR    (trig_addr),
    .AUTO_FLAG    (auto_f),
    .WR_EN        (wr_en),
    .WR_ADDR      (wr_addr),
    .WR_DATA      (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC driver model: registered clock, new sample on its rise
  initial begin
    int hcnt;
    hcnt = 0;
    clk_adc = 1'b0;
    sample = '0;
    forever begin
      @(posedge clk);
      #1;
      hcnt++;
      if (hcnt >= hp) begin
        hcnt = 0;
        clk_adc = ~clk_adc;
        if (clk_adc) begin
          rise_cyc = cyc;
          if (stim.size() > 0) begin
            sample = stim.pop_front();
            pres_idx++;
          end
        end
      end
    end
  end

  // RAM write monitor
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
      mram[wr_addr] = int'(wr_data);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int smp(input int k);
    if (stream.size() == 0) return 0;
    if (k < stream.size()) return stream[k];
    return stream[stream.size()-1];
  endfunction

  function automatic int model_trig(input int lvl, input bit sl,
                                    input int hor);
    int p;
    int c;
    bit hit;
    m_auto = 1'b0;
    for (int k = PRE; k < hor; k++) begin
      p = smp(k - 1);
      c = smp(k);
      hit = sl ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
      if (hit) return k;
`ifdef ADC_TRIG_AUTO_EN
      if (k - PRE + 1 == ATO) begin
        m_auto = 1'b1;
        return k;
      end
`endif
    end
    return -1;
  endfunction

  task automatic mk_ramp(input int start, input int step, input int len);
    int v;
    stream.delete();
    for (int k = 0; k < len; k++) begin
      v = start + step * k;
      if (v < 0) v = 0;
      if (v > 511) v = 511;
      stream.push_back(v);
    end
  endtask

  task automatic start_cap(input int lvl, input bit sl);
    bit found;
    level = 9'(lvl);
    slope = sl;
    found = 1'b0;
    for (int i = 0; i < 4 * hp + 8; i++) begin
      @(posedge clk);
      #2;
      if (rise_cyc == cyc) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("align_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    arm = 1'b1;
    stim.delete();
    foreach (stream[i]) stim.push_back(9'(stream[i]));
    pres_idx = 0;
    wa.delete();
    wd.delete();
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic wait_writes(input string nm, input int n);
    for (int i = 0; i < 64 * hp && wa.size() < n; i++)
      @(negedge clk);
    if (wa.size() < n) chk(nm, wa.size(), n);
  endtask

  task automatic capture(input string tag, input int lvl, input bit sl);
    int t;
    int n;
    int nbad;
    int hor;
    hor = stream.size() + 16;
    t = model_trig(lvl, sl, hor);
    start_cap(lvl, sl);
    if (t >= 0) begin
      for (int i = 0; i < (t + POSTN + 4) * 2 * hp + 40; i++) begin
        @(negedge clk);
        if (done) break;
      end
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_trig_addr"}, int'(trig_addr), t % DEPTH);
      chk({tag, "_auto"}, int'(auto_f), int'(m_auto));
      chk({tag, "_busy"}, int'(busy), 0);
      repeat (4 * hp) @(negedge clk);
      n = t + POSTN;
      chk({tag, "_nwrites"}, wa.size(), n);
    end else begin
      repeat (hor * 2 * hp) @(negedge clk);
      chk({tag, "_nodone"}, int'(done), 0);
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_auto"}, int'(auto_f), 0);
      n = wa.size();
    end
    nbad = 0;
    for (int k = 0; k < n && k < wa.size(); k++)
      if (wa[k] != k % DEPTH || wd[k] != smp(k)) nbad++;
    chk({tag, "_wlog_bad"}, nbad, 0);
    if (t >= 0)
      chk({tag, "_oldest"}, mram[(t - PRE) % DEPTH], smp(t - PRE));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_trig_addr"}, int'(trig_addr), 0);
    chk({tag, "_auto"}, int'(auto_f), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
  endtask

  initial begin
    bit found;
    int d;
    int n0;

    tab[0] = '{0, 10, 100, 1'b0, 40, 1'b1, 10};
    tab[1] = '{200, -10, 150, 1'b1, 40, 1'b1, 5};
`ifdef ADC_TRIG_AUTO_EN
    tab[2] = '{150, 0, 150, 1'b1, 30, 1'b1, 11};
    tab[3] = '{500, -20, 100, 1'b0, 40, 1'b1, 11};
    tab[4] = '{0, 40, 511, 1'b0, 40, 1'b1, 11};
`else
    tab[2] = '{150, 0, 150, 1'b1, 30, 1'b0, 0};
    tab[3] = '{500, -20, 100, 1'b0, 40, 1'b0, 0};
    tab[4] = '{0, 40, 511, 1'b0, 40, 1'b1, 13};
`endif
    tab[5] = '{100, -30, 0, 1'b1, 40, 1'b1, 4};

    rst_n = 1'b0;
    arm = 1'b0;
    level = '0;
    slope = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // strobe spacing and latency with a slow ADC clock
    stream.delete();
    repeat (8) stream.push_back(0);
    start_cap(0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      found = 1'b0;
      for (int i = 0; i < 1100; i++) begin
        @(negedge clk);
        if (wr_en) begin
          found = 1'b1;
          break;
        end
      end
      chk("stb_seen", int'(found), 1);
      if (found) chk("stb_latency", cyc - rise_cyc, 2);
      @(negedge clk);
      chk("stb_width", int'(wr_en), 0);
    end
    wa.delete();
    repeat (4096) @(negedge clk);
    chk("stb_count", wa.size(), 4);
    hp = 4;

    // table-driven ramps and flats
    for (int i = 0; i < 6; i++) begin
      mk_ramp(tab[i].start, tab[i].step, tab[i].len);
      capture($sformatf("tab%0d", i), tab[i].lvl, tab[i].slope);
      chk($sformatf("tab%0d_exp_done", i), int'(done),
          int'(tab[i].exp_done));
      if (tab[i].exp_done)
        chk($sformatf("tab%0d_exp_addr", i), int'(trig_addr),
            tab[i].exp_addr);
    end

    // crossing during PRE is ignored, later one in WAIT triggers
    stream = '{90, 110, 90, 90, 90, 90, 110};
    repeat (23) stream.push_back(110);
    capture("precross", 100, 1'b0);
    chk("precross_addr", int'(trig_addr), 6);

    // random streams against the model
    for (int r = 0; r < 6; r++) begin
      stream.delete();
      repeat (40) stream.push_back(int'($urandom_range(511, 0)));
      capture($sformatf("rand%0d", r), int'($urandom_range(450, 50)),
              1'($urandom_range(1, 0)));
    end

    // ARM coincident with a strobe in POST
    mk_ramp(0, 10, 40);
    start_cap(100, 1'b0);
    wait_writes("co_post_timeout", 13);
    found = 1'b0;
    for (int i = 0; i < 4 * hp + 8; i++) begin
      @(posedge clk);
      #2;
      if (rise_cyc == cyc) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("co_align_timeout", 0, 1);
    d = pres_idx;
    @(posedge clk);
    #1;
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    @(negedge clk);
    chk("co_wr_en", int'(wr_en), 0);
    chk("co_done", int'(done), 0);
    chk("co_busy", int'(busy), 1);
    n0 = wa.size();
    wait_writes("co_next_timeout", n0 + 1);
    if (wa.size() > n0) begin
      chk("co_addr", wa[n0], 0);
      chk("co_data", wd[n0], stream[d]);
    end

    // asynchronous reset in the middle of POST
    mk_ramp(0, 10, 40);
    start_cap(100, 1'b0);
    wait_writes("rst_post_timeout", 13);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = wa.size();
    repeat (80) @(negedge clk);
    chk("rst_no_writes", wa.size() - n0, 0);
    chk("rst_idle_busy", int'(busy), 0);
    capture("after_rst", 100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
